// File: rtl/datamover_cmd_master.sv
`default_nettype none
// ============================================================================
// datamover_cmd_master
// Register-programmed AXI DataMover command issuer with status buffering.
// Rev 1.0
// ============================================================================
module datamover_cmd_master #(
  parameter int                            C_S_AXI_ADDR_WIDTH      = 32,
  parameter int                            C_S_AXI_DATA_WIDTH      = 32,
  parameter int                            C_M_AXIS_CMD_DATA_WIDTH = 72,
  parameter int                            C_M_AXIS_STS_DATA_WIDTH = 8,
  parameter int                            C_CMD_FIFO_DEPTH        = 16,
  parameter int                            C_STS_FIFO_DEPTH        = 16,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR             = '0
) (
  input  logic                               clk,
  input  logic                               rst,
  output logic                               M_AXIS_CMD_TVALID,
  input  logic                               M_AXIS_CMD_TREADY,
  output logic [C_M_AXIS_CMD_DATA_WIDTH-1:0] M_AXIS_CMD_TDATA,
  input  logic                               S_AXIS_STS_TVALID,
  output logic                               S_AXIS_STS_TREADY,
  input  logic [C_M_AXIS_STS_DATA_WIDTH-1:0] S_AXIS_STS_TDATA,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]      set_data,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]      set_addr,
  input  logic                               set_stb,
  output logic [C_S_AXI_DATA_WIDTH-1:0]      get_data,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]      get_addr,
  input  logic                               get_stb
);

  localparam int                          c_cmd_aw    = $clog2(C_CMD_FIFO_DEPTH);
  localparam int                          c_sts_aw    = $clog2(C_STS_FIFO_DEPTH);
  localparam logic [c_cmd_aw:0]           c_cmd_depth = (c_cmd_aw+1)'(C_CMD_FIFO_DEPTH);
  localparam logic [c_sts_aw:0]           c_sts_depth = (c_sts_aw+1)'(C_STS_FIFO_DEPTH);
  localparam logic [c_cmd_aw:0]           c_cmd_one   = (c_cmd_aw+1)'(1);
  localparam logic [c_sts_aw:0]           c_sts_one   = (c_sts_aw+1)'(1);
  localparam logic [C_S_AXI_ADDR_WIDTH:0] c_win_lo    = {1'b0, C_BASE_ADDR};
  localparam logic [C_S_AXI_ADDR_WIDTH:0] c_win_size  = (C_S_AXI_ADDR_WIDTH+1)'(16);

  logic [C_M_AXIS_CMD_DATA_WIDTH-1:0] cmd_mem_q [C_CMD_FIFO_DEPTH];
  logic [C_M_AXIS_STS_DATA_WIDTH-1:0] sts_mem_q [C_STS_FIFO_DEPTH];
  logic [c_cmd_aw:0]                  cmd_wr_q, cmd_rd_q;
  logic [c_sts_aw:0]                  sts_wr_q, sts_rd_q;
  logic [31:0]                        saddr_q, ctrl_q;
  logic                               ovf_q, sts_lost_q;
  logic [15:0]                        outstanding_q, outstanding_d;

  logic [c_cmd_aw:0]                  w_cmd_cnt;
  logic [c_sts_aw:0]                  w_sts_cnt;
  logic                               w_cmd_empty, w_cmd_full, w_sts_empty, w_sts_full;
  logic                               w_set_hit, w_get_hit;
  logic                               w_wr_addr, w_wr_ctrl, w_wr_clear, w_flush;
  logic                               w_cmd_push, w_cmd_hs, w_sts_hs, w_sts_pop;
  logic [C_M_AXIS_CMD_DATA_WIDTH-1:0] w_cmd_word;
  logic [C_M_AXIS_STS_DATA_WIDTH-1:0] w_sts_head;

  // Occupancy from pointer difference; the extra MSB distinguishes full from empty.
  assign w_cmd_cnt   = cmd_wr_q - cmd_rd_q;
  assign w_sts_cnt   = sts_wr_q - sts_rd_q;
  assign w_cmd_empty = (w_cmd_cnt == '0);
  assign w_cmd_full  = (w_cmd_cnt == c_cmd_depth);
  assign w_sts_empty = (w_sts_cnt == '0);
  assign w_sts_full  = (w_sts_cnt == c_sts_depth);

  // Relative offset wraps to a huge value below the base, so one compare bounds both ends.
  assign w_set_hit  = set_stb && (({1'b0, set_addr} - c_win_lo) < c_win_size);
  assign w_get_hit  = (({1'b0, get_addr} - c_win_lo) < c_win_size);
  assign w_wr_addr  = w_set_hit && (set_addr[3:2] == 2'd0);
  assign w_wr_ctrl  = w_set_hit && (set_addr[3:2] == 2'd1);
  assign w_wr_clear = w_set_hit && (set_addr[3:2] == 2'd3);
  assign w_flush    = w_wr_clear && set_data[2];

  assign w_cmd_word = {4'b0000, set_data[27:24], saddr_q, 1'b0, set_data[23],
                       6'b000000, 1'b1, set_data[22:0]};
  assign w_cmd_push = w_wr_ctrl && !w_cmd_full && !w_flush;
  assign w_cmd_hs   = M_AXIS_CMD_TVALID && M_AXIS_CMD_TREADY;
  assign w_sts_hs   = S_AXIS_STS_TVALID && S_AXIS_STS_TREADY;
  assign w_sts_pop  = get_stb && w_get_hit && (get_addr[3:2] == 2'd2) && !w_sts_empty;
  assign w_sts_head = w_sts_empty ? '0 : sts_mem_q[sts_rd_q[c_sts_aw-1:0]];

  assign M_AXIS_CMD_TVALID = !w_cmd_empty && !rst;
  assign M_AXIS_CMD_TDATA  = M_AXIS_CMD_TVALID ? cmd_mem_q[cmd_rd_q[c_cmd_aw-1:0]] : '0;
  assign S_AXIS_STS_TREADY = !w_sts_full && !rst;

  always_comb begin
    outstanding_d = outstanding_q;
    if (w_cmd_hs && !w_sts_hs && (outstanding_q != 16'hFFFF)) begin
      outstanding_d = outstanding_q + 16'd1;
    end else if (w_sts_hs && !w_cmd_hs && (outstanding_q != 16'd0)) begin
      outstanding_d = outstanding_q - 16'd1;
    end
  end

  always_comb begin
    get_data = '0;
    if (w_get_hit) begin
      case (get_addr[3:2])
        2'd0:    get_data = saddr_q;
        2'd1:    get_data = ctrl_q;
        2'd2:    get_data = {outstanding_q, 4'b0000, sts_lost_q, ovf_q, w_cmd_full,
                             !w_sts_empty, w_sts_head};
        default: get_data = '0;
      endcase
    end
  end

  // Storage arrays carry no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (w_cmd_push) cmd_mem_q[cmd_wr_q[c_cmd_aw-1:0]] <= w_cmd_word;
    if (w_sts_hs && !w_flush) sts_mem_q[sts_wr_q[c_sts_aw-1:0]] <= S_AXIS_STS_TDATA;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_wr_q      <= '0;
      cmd_rd_q      <= '0;
      sts_wr_q      <= '0;
      sts_rd_q      <= '0;
      saddr_q       <= '0;
      ctrl_q        <= '0;
      ovf_q         <= 1'b0;
      sts_lost_q    <= 1'b0;
      outstanding_q <= '0;
    end else begin
      if (w_wr_addr) saddr_q <= set_data;
      if (w_wr_ctrl) ctrl_q  <= set_data;

      if (w_wr_ctrl && w_cmd_full) ovf_q <= 1'b1;
      else if (w_wr_clear && set_data[0]) ovf_q <= 1'b0;

      // A loss in the same cycle as its clear is kept so the event is never hidden.
      if (S_AXIS_STS_TVALID && w_sts_full) sts_lost_q <= 1'b1;
      else if (w_wr_clear && set_data[1]) sts_lost_q <= 1'b0;

      if (w_flush) begin
        cmd_wr_q      <= '0;
        cmd_rd_q      <= '0;
        sts_wr_q      <= '0;
        sts_rd_q      <= '0;
        outstanding_q <= '0;
      end else begin
        if (w_cmd_push) cmd_wr_q <= cmd_wr_q + c_cmd_one;
        if (w_cmd_hs)   cmd_rd_q <= cmd_rd_q + c_cmd_one;
        if (w_sts_hs)   sts_wr_q <= sts_wr_q + c_sts_one;
        if (w_sts_pop)  sts_rd_q <= sts_rd_q + c_sts_one;
        outstanding_q <= outstanding_d;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_datamover_cmd_master.sv
`default_nettype none
// ============================================================================
// tb_datamover_cmd_master
// Directed and randomised bench checked against a queue-based reference model.
// Rev 1.0
// ============================================================================
module tb_datamover_cmd_master;

  localparam int c_depth = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        M_AXIS_CMD_TVALID, M_AXIS_CMD_TREADY;
  logic [71:0] M_AXIS_CMD_TDATA;
  logic        S_AXIS_STS_TVALID, S_AXIS_STS_TREADY;
  logic [7:0]  S_AXIS_STS_TDATA;
  logic [31:0] set_data, set_addr, get_data, get_addr;
  logic        set_stb, get_stb;

  always #5 clk = ~clk;

  datamover_cmd_master dut (
    .clk              (clk),
    .rst              (rst),
    .M_AXIS_CMD_TVALID(M_AXIS_CMD_TVALID),
    .M_AXIS_CMD_TREADY(M_AXIS_CMD_TREADY),
    .M_AXIS_CMD_TDATA (M_AXIS_CMD_TDATA),
    .S_AXIS_STS_TVALID(S_AXIS_STS_TVALID),
    .S_AXIS_STS_TREADY(S_AXIS_STS_TREADY),
    .S_AXIS_STS_TDATA (S_AXIS_STS_TDATA),
    .set_data         (set_data),
    .set_addr         (set_addr),
    .set_stb          (set_stb),
    .get_data         (get_data),
    .get_addr         (get_addr),
    .get_stb          (get_stb)
  );

  int          n_vec = 0;
  int          n_err = 0;

  logic [71:0] m_cmd_q[$];
  logic [7:0]  m_sts_q[$];
  logic [31:0] m_saddr, m_ctrl;
  bit          m_ovf, m_lost;
  int          m_out;

  function automatic logic [71:0] mk_cmd(input logic [31:0] sa, input logic [31:0] c);
    return {4'h0, c[27:24], sa, 1'b0, c[23], 6'h00, 1'b1, c[22:0]};
  endfunction

  function automatic logic [31:0] exp_get(input logic [31:0] a);
    logic [7:0] head;
    head = (m_sts_q.size() != 0) ? m_sts_q[0] : 8'h00;
    if (a > 32'hF) return 32'h0;
    case (a[3:2])
      2'd0:    return m_saddr;
      2'd1:    return m_ctrl;
      2'd2:    return {m_out[15:0], 4'h0, m_lost, m_ovf, (m_cmd_q.size() == c_depth),
                       (m_sts_q.size() != 0), head};
      default: return 32'h0;
    endcase
  endfunction

  // Advances the reference by one clock using the inputs presented this cycle.
  task automatic model_tick();
    int cs, ss;
    bit cmd_hs, sts_hs, hit, flush;
    if (rst) begin
      m_cmd_q.delete(); m_sts_q.delete();
      m_saddr = 0; m_ctrl = 0; m_ovf = 0; m_lost = 0; m_out = 0;
      return;
    end
    cs     = m_cmd_q.size();
    ss     = m_sts_q.size();
    cmd_hs = M_AXIS_CMD_TREADY && (cs > 0);
    sts_hs = S_AXIS_STS_TVALID && (ss < c_depth);
    hit    = set_stb && (set_addr < 32'd16);
    flush  = hit && (set_addr[3:2] == 2'd3) && set_data[2];
    if (S_AXIS_STS_TVALID && ss == c_depth) m_lost = 1;
    else if (hit && set_addr[3:2] == 2'd3 && set_data[1]) m_lost = 0;
    if (hit && set_addr[3:2] == 2'd3 && set_data[0]) m_ovf = 0;
    if (flush) begin
      m_cmd_q.delete(); m_sts_q.delete(); m_out = 0;
    end else begin
      if (cmd_hs) void'(m_cmd_q.pop_front());
      if (get_stb && get_addr < 32'd16 && get_addr[3:2] == 2'd2 && ss > 0)
        void'(m_sts_q.pop_front());
      if (sts_hs) m_sts_q.push_back(S_AXIS_STS_TDATA);
      if (hit && set_addr[3:2] == 2'd1) begin
        if (cs == c_depth) m_ovf = 1;
        else m_cmd_q.push_back(mk_cmd(m_saddr, set_data));
      end
      if (cmd_hs && !sts_hs && m_out < 65535) m_out++;
      else if (sts_hs && !cmd_hs && m_out > 0) m_out--;
    end
    if (hit && set_addr[3:2] == 2'd0) m_saddr = set_data;
    if (hit && set_addr[3:2] == 2'd1) m_ctrl = set_data;
  endtask

  task automatic step();
    model_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    set_addr = a; set_data = d; set_stb = 1'b1;
    step();
    set_stb = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] a;
    rst = 1'b1;
    step(); step();
    n_vec++; if (M_AXIS_CMD_TVALID !== 1'b0) begin n_err++; $display("FAIL rst_tvalid: got %b exp 0", M_AXIS_CMD_TVALID); end
    n_vec++; if (M_AXIS_CMD_TDATA !== 72'h0) begin n_err++; $display("FAIL rst_tdata: got %h exp 0", M_AXIS_CMD_TDATA); end
    n_vec++; if (S_AXIS_STS_TREADY !== 1'b0) begin n_err++; $display("FAIL rst_sts_tready: got %b exp 0", S_AXIS_STS_TREADY); end
    rst = 1'b0;
    step();
    n_vec++; if (S_AXIS_STS_TREADY !== 1'b1) begin n_err++; $display("FAIL post_rst_sts_tready: got %b exp 1", S_AXIS_STS_TREADY); end
    for (int i = 0; i < 3; i++) begin
      a = 32'(i * 4);
      get_addr = a; #1;
      n_vec++; if (get_data !== 32'h0) begin n_err++; $display("FAIL post_rst_reg%0h: got %h exp 0", a, get_data); end
    end
  endtask

  task automatic test_single_cmd();
    M_AXIS_CMD_TREADY = 1'b1;
    wr(32'h0, 32'h1000_0000);
    wr(32'h4, 32'h0300_0040);
    n_vec++; if (M_AXIS_CMD_TVALID !== 1'b1) begin n_err++; $display("FAIL single_tvalid: got %b exp 1", M_AXIS_CMD_TVALID); end
    n_vec++; if (M_AXIS_CMD_TDATA !== 72'h03_1000_0000_0080_0040) begin n_err++; $display("FAIL single_tdata: got %h exp 031000000000800040", M_AXIS_CMD_TDATA); end
    step();
    M_AXIS_CMD_TREADY = 1'b0;
    get_addr = 32'h8; #1;
    n_vec++; if (get_data !== 32'h0001_0000) begin n_err++; $display("FAIL single_outstanding: got %h exp 00010000", get_data); end
    n_vec++; if (M_AXIS_CMD_TVALID !== 1'b0) begin n_err++; $display("FAIL single_drained: got %b exp 0", M_AXIS_CMD_TVALID); end
    get_addr = 32'h4; #1;
    n_vec++; if (get_data !== 32'h0300_0040) begin n_err++; $display("FAIL ctrl_readback: got %h exp 03000040", get_data); end
  endtask

  task automatic test_cmd_overflow();
    logic [71:0] exp_q[$];
    logic [31:0] sa, c;
    M_AXIS_CMD_TREADY = 1'b0;
    sa = $urandom;
    wr(32'h0, sa);
    for (int i = 0; i < 17; i++) begin
      c = $urandom & 32'h0FFF_FFFF;
      if (i < 16) exp_q.push_back(mk_cmd(sa, c));
      wr(32'h4, c);
    end
    get_addr = 32'h8; #1;
    n_vec++; if (get_data[9] !== 1'b1) begin n_err++; $display("FAIL ovf_cmd_full: got %b exp 1", get_data[9]); end
    n_vec++; if (get_data[10] !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b exp 1", get_data[10]); end
    M_AXIS_CMD_TREADY = 1'b1;
    for (int i = 0; i < 16; i++) begin
      n_vec++; if (M_AXIS_CMD_TVALID !== 1'b1 || M_AXIS_CMD_TDATA !== exp_q[i]) begin n_err++; $display("FAIL ovf_order[%0d]: got v=%b %h exp v=1 %h", i, M_AXIS_CMD_TVALID, M_AXIS_CMD_TDATA, exp_q[i]); end
      step();
    end
    M_AXIS_CMD_TREADY = 1'b0;
    n_vec++; if (M_AXIS_CMD_TVALID !== 1'b0) begin n_err++; $display("FAIL ovf_drained: got %b exp 0", M_AXIS_CMD_TVALID); end
    wr(32'hC, 32'h1);
    get_addr = 32'h8; #1;
    n_vec++; if (get_data !== 32'h0011_0000) begin n_err++; $display("FAIL ovf_clear: got %h exp 00110000", get_data); end
  endtask

  task automatic test_status();
    wr(32'hC, 32'h4);
    M_AXIS_CMD_TREADY = 1'b1;
    wr(32'h4, $urandom & 32'h0FFF_FFFF);
    step();
    M_AXIS_CMD_TREADY = 1'b0;
    S_AXIS_STS_TVALID = 1'b1; S_AXIS_STS_TDATA = 8'h83;
    step();
    S_AXIS_STS_TVALID = 1'b0;
    get_addr = 32'h8; #1;
    n_vec++; if (get_data !== 32'h0000_0183) begin n_err++; $display("FAIL status_read: got %h exp 00000183", get_data); end
    get_stb = 1'b1; #1;
    n_vec++; if (get_data !== 32'h0000_0183) begin n_err++; $display("FAIL status_pop_data: got %h exp 00000183", get_data); end
    step();
    get_stb = 1'b0; #1;
    n_vec++; if (get_data !== 32'h0) begin n_err++; $display("FAIL status_after_pop: got %h exp 0", get_data); end
  endtask

  task automatic test_status_overflow();
    logic [7:0] exp_q[$];
    logic [7:0] d;
    S_AXIS_STS_TVALID = 1'b1;
    for (int i = 0; i < 16; i++) begin
      d = 8'($urandom);
      exp_q.push_back(d);
      S_AXIS_STS_TDATA = d;
      step();
    end
    n_vec++; if (S_AXIS_STS_TREADY !== 1'b0) begin n_err++; $display("FAIL sts_full_tready: got %b exp 0", S_AXIS_STS_TREADY); end
    S_AXIS_STS_TDATA = 8'hEE;
    step();
    S_AXIS_STS_TVALID = 1'b0;
    get_addr = 32'h8; #1;
    n_vec++; if (get_data[11] !== 1'b1) begin n_err++; $display("FAIL sts_lost: got %b exp 1", get_data[11]); end
    n_vec++; if (get_data[31:16] !== 16'h0) begin n_err++; $display("FAIL sts_outstanding_floor: got %h exp 0", get_data[31:16]); end
    get_stb = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      n_vec++; if (get_data[8] !== 1'b1 || get_data[7:0] !== exp_q[i]) begin n_err++; $display("FAIL sts_order[%0d]: got v=%b %h exp v=1 %h", i, get_data[8], get_data[7:0], exp_q[i]); end
      step();
    end
    get_stb = 1'b0; #1;
    n_vec++; if (get_data[8] !== 1'b0 || S_AXIS_STS_TREADY !== 1'b1) begin n_err++; $display("FAIL sts_drained: got v=%b rdy=%b exp v=0 rdy=1", get_data[8], S_AXIS_STS_TREADY); end
    wr(32'hC, 32'h2);
    get_addr = 32'h8; #1;
    n_vec++; if (get_data[11] !== 1'b0) begin n_err++; $display("FAIL sts_lost_clear: got %b exp 0", get_data[11]); end
  endtask

  task automatic test_simultaneous();
    M_AXIS_CMD_TREADY = 1'b0;
    wr(32'h4, 32'h0000_0010);
    wr(32'h4, 32'h0000_0020);
    M_AXIS_CMD_TREADY = 1'b1;
    step();
    M_AXIS_CMD_TREADY = 1'b1; S_AXIS_STS_TVALID = 1'b1; S_AXIS_STS_TDATA = 8'h01;
    step();
    M_AXIS_CMD_TREADY = 1'b0; S_AXIS_STS_TVALID = 1'b0;
    get_addr = 32'h8; #1;
    n_vec++; if (get_data[31:16] !== 16'd1) begin n_err++; $display("FAIL both_hs_outstanding: got %0d exp 1", get_data[31:16]); end
    S_AXIS_STS_TVALID = 1'b1; S_AXIS_STS_TDATA = 8'h02;
    step(); step();
    S_AXIS_STS_TVALID = 1'b0; #1;
    n_vec++; if (get_data[31:16] !== 16'd0) begin n_err++; $display("FAIL sts_at_zero: got %0d exp 0", get_data[31:16]); end
    get_stb = 1'b1;
    step(); step(); step();
    get_stb = 1'b0;
  endtask

  task automatic test_flush_push();
    M_AXIS_CMD_TREADY = 1'b0;
    for (int i = 0; i < 17; i++) wr(32'h4, $urandom & 32'h0FFF_FFFF);
    S_AXIS_STS_TVALID = 1'b1; S_AXIS_STS_TDATA = 8'h5A;
    wr(32'hC, 32'h4);
    S_AXIS_STS_TVALID = 1'b0;
    get_addr = 32'h8; #1;
    n_vec++; if (get_data !== 32'h0000_0400 || M_AXIS_CMD_TVALID !== 1'b0) begin n_err++; $display("FAIL flush_wins: got %h v=%b exp 00000400 v=0", get_data, M_AXIS_CMD_TVALID); end
    wr(32'hC, 32'h1);
  endtask

  task automatic test_reset_mid();
    M_AXIS_CMD_TREADY = 1'b0;
    wr(32'h0, 32'hDEAD_BEEF);
    for (int i = 0; i < 4; i++) wr(32'h4, 32'(i + 1));
    n_vec++; if (M_AXIS_CMD_TVALID !== 1'b1) begin n_err++; $display("FAIL mid_queued: got %b exp 1", M_AXIS_CMD_TVALID); end
    rst = 1'b1; #1;
    n_vec++; if (M_AXIS_CMD_TVALID !== 1'b0 || S_AXIS_STS_TREADY !== 1'b0) begin n_err++; $display("FAIL mid_rst_outputs: got v=%b rdy=%b exp 0 0", M_AXIS_CMD_TVALID, S_AXIS_STS_TREADY); end
    step();
    rst = 1'b0; M_AXIS_CMD_TREADY = 1'b1;
    step();
    n_vec++; if (M_AXIS_CMD_TVALID !== 1'b0 || S_AXIS_STS_TREADY !== 1'b1) begin n_err++; $display("FAIL mid_after: got v=%b rdy=%b exp 0 1", M_AXIS_CMD_TVALID, S_AXIS_STS_TREADY); end
    get_addr = 32'h0; #1;
    n_vec++; if (get_data !== 32'h0) begin n_err++; $display("FAIL mid_saddr: got %h exp 0", get_data); end
    get_addr = 32'h8; #1;
    n_vec++; if (get_data !== 32'h0) begin n_err++; $display("FAIL mid_status: got %h exp 0", get_data); end
    M_AXIS_CMD_TREADY = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] addr_tbl [8];
    logic [31:0] exp_d;
    int          thr_c, thr_s, r;
    addr_tbl = '{32'h0, 32'h4, 32'h8, 32'h8, 32'h8, 32'hC, 32'h18, 32'h108};
    for (int cyc = 0; cyc < 800; cyc++) begin
      thr_c = (cyc / 100) % 4;
      thr_s = ((cyc / 100) + 2) % 4;
      M_AXIS_CMD_TREADY = (($urandom % 4) < thr_c);
      S_AXIS_STS_TVALID = (($urandom % 4) < thr_s);
      S_AXIS_STS_TDATA  = 8'($urandom);
      set_stb = (($urandom % 8) < 3);
      r = $urandom % 16;
      if (r < 2)       begin set_addr = 32'h0;  set_data = $urandom; end
      else if (r < 10) begin set_addr = 32'h4;  set_data = $urandom; end
      else if (r == 10) begin set_addr = 32'h8; set_data = $urandom; end
      else if (r == 11) begin set_addr = 32'h14; set_data = $urandom; end
      else begin
        set_addr = 32'hC;
        set_data = ($urandom & 32'h3) | ((($urandom % 8) == 0) ? 32'h4 : 32'h0);
      end
      get_stb  = (($urandom % 4) == 0);
      get_addr = addr_tbl[$urandom % 8];
      #1;
      n_vec++; if (M_AXIS_CMD_TVALID !== (m_cmd_q.size() != 0)) begin n_err++; $display("FAIL rnd_tvalid @%0d: got %b exp %b", cyc, M_AXIS_CMD_TVALID, m_cmd_q.size() != 0); end
      n_vec++; if (M_AXIS_CMD_TDATA !== ((m_cmd_q.size() != 0) ? m_cmd_q[0] : 72'h0)) begin n_err++; $display("FAIL rnd_tdata @%0d: got %h", cyc, M_AXIS_CMD_TDATA); end
      n_vec++; if (S_AXIS_STS_TREADY !== (m_sts_q.size() < c_depth)) begin n_err++; $display("FAIL rnd_sts_tready @%0d: got %b exp %b", cyc, S_AXIS_STS_TREADY, m_sts_q.size() < c_depth); end
      exp_d = exp_get(get_addr);
      n_vec++; if (get_data !== exp_d) begin n_err++; $display("FAIL rnd_get_data @%0d addr %h: got %h exp %h", cyc, get_addr, get_data, exp_d); end
      step();
    end
    set_stb = 1'b0; get_stb = 1'b0; M_AXIS_CMD_TREADY = 1'b0; S_AXIS_STS_TVALID = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    M_AXIS_CMD_TREADY = 1'b0; S_AXIS_STS_TVALID = 1'b0; S_AXIS_STS_TDATA = 8'h0;
    set_data = 32'h0; set_addr = 32'h0; set_stb = 1'b0;
    get_addr = 32'h0; get_stb = 1'b0;
    test_reset();
    test_single_cmd();
    test_cmd_overflow();
    test_status();
    test_status_overflow();
    test_simultaneous();
    test_flush_push();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
